// File: rtl/pulse_stretcher_vector_pkg.sv
// Shared definitions for the pulse stretcher and other button/LED helpers:
// per-channel state encoding and the hold-counter width rule.
package pulse_stretcher_vector_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } ps_state_e;

   // Down-counter width for a hold of hold_cycles clocks (never narrower than 1 bit).
   function automatic int cnt_w(input int hold_cycles);
      int w;
      w = $clog2(hold_cycles);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/pulse_stretcher.sv
// Single-channel stretcher: turns an active-low strobe into an active-low level
// held for HOLD_CYCLES clocks, using a down-counter with terminal-count compare.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | output high, waiting for a low sample on pulse_n
// ST_HOLD | output low, counter counting down to 0 (0 = last low cycle)
module pulse_stretcher
   import pulse_stretcher_vector_pkg::*;
#(
   parameter int HOLD_CYCLES = 16,
   parameter bit RETRIGGER   = 1'b1
) (
   input  logic clk_ps,
   input  logic reset_n,
   input  logic pulse_n,
   output logic stretched_n,
   output logic busy_next
);

   localparam int               CNT_W  = cnt_w(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

   ps_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stretched_n_q, stretched_n_d;
   logic             pulse;
   logic             cnt_tc;

   assign pulse  = ~pulse_n;
   assign cnt_tc = (cnt_q == '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (pulse) begin
               state_d = ST_HOLD;
               cnt_d   = RELOAD;
            end
         end
         ST_HOLD: begin
            if (!cnt_tc) begin
               if (pulse && RETRIGGER) cnt_d = RELOAD;
               else                    cnt_d = cnt_q - CNT_W'(1);
            end else if (pulse) begin
               // re-arm at expiry in both modes so there is no one-cycle high gap
               cnt_d = RELOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
      stretched_n_d = (state_d != ST_HOLD);
   end

   always_ff @(posedge clk_ps or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         stretched_n_q <= 1'b1;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         stretched_n_q <= stretched_n_d;
      end
   end

   assign stretched_n = stretched_n_q;
   assign busy_next   = (state_d == ST_HOLD);

endmodule

// File: rtl/pulse_stretcher_vector.sv
// Vector of independent pulse stretchers plus a registered "any channel holding"
// flag built from next-state so it lines up with the stretched outputs.
module pulse_stretcher_vector
   import pulse_stretcher_vector_pkg::*;
#(
   parameter int SIGNAL_BIT_WIDTH = 8,
   parameter int HOLD_CYCLES      = 16,
   parameter bit RETRIGGER        = 1'b1
) (
   input  logic                        clk_ps,
   input  logic                        reset_n,
   input  logic [SIGNAL_BIT_WIDTH-1:0] pulses_n,
   output logic [SIGNAL_BIT_WIDTH-1:0] signals_stretched_n,
   output logic                        busy_any
);

   logic [SIGNAL_BIT_WIDTH-1:0] busy_next;
   logic                        busy_any_q, busy_any_d;

   if (SIGNAL_BIT_WIDTH < 1) begin : g_bad_width
      $error("pulse_stretcher_vector: SIGNAL_BIT_WIDTH must be >= 1");
   end
   if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("pulse_stretcher_vector: HOLD_CYCLES must be >= 1");
   end

   for (genvar i = 0; i < SIGNAL_BIT_WIDTH; i++) begin : g_ch
      pulse_stretcher #(
         .HOLD_CYCLES (HOLD_CYCLES),
         .RETRIGGER   (RETRIGGER)
      ) u_ch (
         .clk_ps      (clk_ps),
         .reset_n     (reset_n),
         .pulse_n     (pulses_n[i]),
         .stretched_n (signals_stretched_n[i]),
         .busy_next   (busy_next[i])
      );
   end

   always_comb begin
      busy_any_d = |busy_next;
   end

   always_ff @(posedge clk_ps or negedge reset_n) begin
      if (!reset_n) busy_any_q <= 1'b0;
      else          busy_any_q <= busy_any_d;
   end

   assign busy_any = busy_any_q;

endmodule

// File: tb/tb_pulse_stretcher_vector.sv
// Scoreboard bench: three stretcher configurations driven by shared stimulus,
// checked against a deadline-based model of the hold behaviour.
module tb_pulse_stretcher_vector;

   localparam int W   = 8;
   localparam int NDUT = 3;

   typedef struct {
      logic [W-1:0] sig [NDUT];
      logic         busy [NDUT];
   } exp_t;

   logic         clk_ps;
   logic         reset_n;
   logic [W-1:0] pulses_n;
   logic [W-1:0] sig  [NDUT];
   logic         busy [NDUT];

   int   hc [NDUT];
   bit   rt [NDUT];
   int   dl [NDUT][W];
   int   k;
   int   checks;
   int   failures;
   exp_t exp_q [$];
   exp_t mon_e;

   pulse_stretcher_vector #(.SIGNAL_BIT_WIDTH(W), .HOLD_CYCLES(3), .RETRIGGER(1'b1)) u_dut_r1 (
      .clk_ps(clk_ps), .reset_n(reset_n), .pulses_n(pulses_n),
      .signals_stretched_n(sig[0]), .busy_any(busy[0]));
   pulse_stretcher_vector #(.SIGNAL_BIT_WIDTH(W), .HOLD_CYCLES(3), .RETRIGGER(1'b0)) u_dut_r0 (
      .clk_ps(clk_ps), .reset_n(reset_n), .pulses_n(pulses_n),
      .signals_stretched_n(sig[1]), .busy_any(busy[1]));
   pulse_stretcher_vector #(.SIGNAL_BIT_WIDTH(W), .HOLD_CYCLES(1), .RETRIGGER(1'b1)) u_dut_h1 (
      .clk_ps(clk_ps), .reset_n(reset_n), .pulses_n(pulses_n),
      .signals_stretched_n(sig[2]), .busy_any(busy[2]));

   initial begin
      clk_ps = 1'b0;
      forever #5 clk_ps = ~clk_ps;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h time=%0t", name, act, expv, $time);
      end
   endtask

   // Model: each channel has a deadline edge; output after edge k is low iff k < deadline.
   // A retriggerable channel moves the deadline on every low sample; a
   // non-retriggerable one only once the previous hold has run out.
   task automatic drive_cycle(input logic [W-1:0] p);
      exp_t e;
      pulses_n = p;
      k++;
      for (int d = 0; d < NDUT; d++) begin
         e.busy[d] = 1'b0;
         for (int i = 0; i < W; i++) begin
            if (!p[i] && (rt[d] || k >= dl[d][i])) dl[d][i] = k + hc[d];
            e.sig[d][i] = !(k < dl[d][i]);
            if (k < dl[d][i]) e.busy[d] = 1'b1;
         end
      end
      exp_q.push_back(e);
      @(posedge clk_ps);
      #2;
   endtask

   task automatic do_reset();
      reset_n  = 1'b0;
      pulses_n = '0;
      exp_q.delete();
      for (int d = 0; d < NDUT; d++)
         for (int i = 0; i < W; i++) dl[d][i] = 0;
      #1;
      for (int d = 0; d < NDUT; d++) begin
         check($sformatf("reset_async_sig%0d", d), 32'(sig[d]), 32'hFF);
         check($sformatf("reset_async_busy%0d", d), 32'(busy[d]), 32'h0);
      end
      repeat (2) @(posedge clk_ps);
      #2;
      for (int d = 0; d < NDUT; d++) begin
         check($sformatf("reset_held_sig%0d", d), 32'(sig[d]), 32'hFF);
         check($sformatf("reset_held_busy%0d", d), 32'(busy[d]), 32'h0);
      end
      reset_n  = 1'b1;
      pulses_n = '1;
   endtask

   always @(posedge clk_ps) begin
      #1;
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         for (int d = 0; d < NDUT; d++) begin
            check($sformatf("sb_sig%0d", d), 32'(sig[d]), 32'(mon_e.sig[d]));
            check($sformatf("sb_busy%0d", d), 32'(busy[d]), 32'(mon_e.busy[d]));
         end
      end
   end

   initial begin
      checks   = 0;
      failures = 0;
      k        = 0;
      hc[0] = 3; rt[0] = 1'b1;
      hc[1] = 3; rt[1] = 1'b0;
      hc[2] = 1; rt[2] = 1'b1;
      reset_n  = 1'b1;
      pulses_n = '1;
      #2;
      do_reset();

      // single pulse on bit0
      drive_cycle(8'hFE);
      check("single_first", 32'(sig[0]), 32'hFE);
      drive_cycle(8'hFF);
      drive_cycle(8'hFF);
      check("single_last_low", 32'(sig[0]), 32'hFE);
      drive_cycle(8'hFF);
      check("single_release", 32'(sig[0]), 32'hFF);
      check("single_busy_off", 32'(busy[0]), 32'h0);
      drive_cycle(8'hFF);

      // retrigger vs ignore: pulses two edges apart
      drive_cycle(8'hFE);
      drive_cycle(8'hFF);
      drive_cycle(8'hFE);
      drive_cycle(8'hFF);
      check("retrig1_still_low", 32'(sig[0]), 32'hFE);
      check("retrig0_released", 32'(sig[1]), 32'hFF);
      drive_cycle(8'hFF);
      drive_cycle(8'hFF);
      check("retrig1_released", 32'(sig[0]), 32'hFF);
      drive_cycle(8'hFF);

      // independence: bit0 then bit7
      drive_cycle(8'hFE);
      drive_cycle(8'h7F);
      check("indep_both", 32'(sig[0]), 32'h7E);
      drive_cycle(8'hFF);
      drive_cycle(8'hFF);
      check("indep_bit7_only", 32'(sig[0]), 32'h7F);
      drive_cycle(8'hFF);
      check("indep_done", 32'(sig[0]), 32'hFF);
      drive_cycle(8'hFF);

      // input held low for several cycles
      repeat (7) drive_cycle(8'h00);
      check("held_low_r0", 32'(sig[1]), 32'h00);
      repeat (5) drive_cycle(8'hFF);

      // asynchronous reset in the middle of a hold, then normal operation
      drive_cycle(8'hFE);
      drive_cycle(8'hFF);
      check("pre_reset_hold", 32'(sig[0]), 32'hFE);
      do_reset();
      drive_cycle(8'hFD);
      check("post_reset_pulse", 32'(sig[0]), 32'hFD);
      repeat (4) drive_cycle(8'hFF);

      // randomized traffic, each bit low with probability 1/4
      for (int n = 0; n < 400; n++) drive_cycle(~($urandom() & $urandom()));
      repeat (5) drive_cycle(8'hFF);

      @(posedge clk_ps);
      #2;
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
